// File: rtl/eval_console_sink.sv
// Multi-lane evaluator console sink: per-lane FIFOs merged round-robin
// onto one channel-tagged character stream, with halt/drain/done tracking.
module eval_console_sink #(
  parameter int CHANNELS   = 2,
  parameter int DATA_W     = 32,
  parameter int CHAR_W     = 8,
  parameter int DEPTH      = 16,
  parameter int IDLE_LIMIT = 1024,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       in_halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHAR_W-1:0]          out_char,
  output logic [CH_W-1:0]            out_chan,
  output logic [CHANNELS-1:0]        overflow,
  output logic                       timeout,
  output logic                       done,
  output logic [31:0]                char_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CHAR_W-1:0]   r_mem [CHANNELS][DEPTH];
  logic [AW:0]         r_wptr [CHANNELS];
  logic [AW:0]         r_rptr [CHANNELS];
  logic [CH_W-1:0]     r_rr;
  logic                r_out_valid;
  logic [CHAR_W-1:0]   r_out_char;
  logic [CH_W-1:0]     r_out_chan;
  logic [CHANNELS-1:0] r_overflow;
  logic                r_timeout;
  logic                r_done;
  logic [31:0]         r_count;
  logic [IW-1:0]       r_idle;

  logic [CHANNELS-1:0] w_empty;
  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_drop;
  logic [CHANNELS-1:0] w_pop;
  logic                w_run;
  logic                w_load;
  logic                w_found;
  logic [CH_W-1:0]     w_grant;
  logic [CHAR_W-1:0]   w_head;
  logic                w_unused;

  assign w_run    = (r_state == S_RUN);
  assign w_load   = ~r_out_valid | out_ready;
  assign w_unused = ^in_data;

  // Full/empty come from start-of-cycle pointers, so a same-cycle pop
  // never makes room for a push and a push never bypasses to the output.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_push  = '0;
    w_drop  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][AW] != r_rptr[i][AW]) &&
                   (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
      w_push[i]  = in_valid[i] & w_run & ~w_full[i];
      w_drop[i]  = in_valid[i] & w_run & w_full[i];
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_head  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_found && !w_empty[i] &&
            i == (int'(r_rr) + k) % CHANNELS) begin
          w_found = 1'b1;
          w_grant = CH_W'(i);
          w_head  = r_mem[i][r_rptr[i][AW-1:0]];
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_pop[i] = w_load & w_found & (int'(w_grant) == i);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++)
      if (w_push[i])
        r_mem[i][r_wptr[i][AW-1:0]] <=
          in_data[i*DATA_W +: CHAR_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
      end
      r_overflow <= r_overflow | w_drop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_char  <= '0;
      r_out_chan  <= '0;
      r_rr        <= '0;
      r_count     <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_char <= w_head;
          r_out_chan <= w_grant;
          r_rr <= (int'(w_grant) == CHANNELS - 1) ?
                  '0 : w_grant + 1'b1;
        end
      end
      if (r_out_valid && out_ready && r_count != 32'hFFFF_FFFF)
        r_count <= r_count + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN:
          if (in_halt) r_state <= S_DRAIN;
        S_DRAIN:
          if (&w_empty && !r_out_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        S_DONE:
          r_done <= 1'b1;
        default:
          r_state <= S_RUN;
      endcase
    end
  end

  // Watchdog only observes the lanes while capture is live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else if (w_run) begin
      if (|in_valid) begin
        r_idle <= '0;
      end else if (r_idle != IW'(IDLE_LIMIT)) begin
        r_idle <= r_idle + 1'b1;
        if (r_idle == IW'(IDLE_LIMIT - 1))
          r_timeout <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_char   = r_out_char;
  assign out_chan   = r_out_chan;
  assign overflow   = r_overflow;
  assign timeout    = r_timeout;
  assign done       = r_done;
  assign char_count = r_count;

endmodule

// File: tb/tb_eval_console_sink.sv
// Bench for eval_console_sink: directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_eval_console_sink;

  localparam int CH  = 2;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int DEP = 16;
  localparam int LIM = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   in_valid;
  logic [CH*DW-1:0] in_data;
  logic            in_halt;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_char;
  logic            out_chan;
  logic [CH-1:0]   overflow;
  logic            timeout;
  logic            done;
  logic [31:0]     char_count;

  int errors = 0;
  int checks = 0;

  eval_console_sink #(
    .CHANNELS(CH), .DATA_W(DW), .CHAR_W(CW),
    .DEPTH(DEP), .IDLE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_halt(in_halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .out_chan(out_chan),
    .overflow(overflow), .timeout(timeout), .done(done),
    .char_count(char_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: one queue per lane plus a one-entry output slot.
  logic [7:0]  mq0[$];
  logic [7:0]  mq1[$];
  logic        m_ov;
  logic [7:0]  m_char;
  logic        m_chan;
  int          m_rr;
  int          m_st;
  int          m_idle;
  logic        m_to;
  logic [1:0]  m_ovf;
  logic [31:0] m_cnt;

  logic [8:0]  got[$];
  bit          last_hs;

  function automatic void m_reset();
    mq0.delete(); mq1.delete();
    m_ov = 0; m_char = 0; m_chan = 0; m_rr = 0; m_st = 0;
    m_idle = 0; m_to = 0; m_ovf = 0; m_cnt = 0;
  endfunction

  function automatic void m_step(logic [1:0] v, logic [7:0] d0,
                                 logic [7:0] d1, logic h, logic r);
    int s0, s1, g;
    bit ld, ovp;
    s0 = mq0.size(); s1 = mq1.size();
    ovp = m_ov; ld = !m_ov || r; g = -1;
    if (m_ov && r && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (ld)
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (m_rr + k) % 2;
        if (g < 0 && (c == 0 ? s0 : s1) > 0) g = c;
      end
    if (m_st == 0) begin
      if (v[0]) begin
        if (s0 == DEP) m_ovf[0] = 1; else mq0.push_back(d0);
      end
      if (v[1]) begin
        if (s1 == DEP) m_ovf[1] = 1; else mq1.push_back(d1);
      end
      if (v != 0) m_idle = 0;
      else if (m_idle < LIM) m_idle++;
      if (m_idle == LIM) m_to = 1;
    end
    if (ld) begin
      if (g >= 0) begin
        m_char = (g == 0) ? mq0.pop_front() : mq1.pop_front();
        m_chan = g[0];
        m_rr = (g + 1) % 2;
        m_ov = 1;
      end else m_ov = 0;
    end
    if (m_st == 0 && h) m_st = 1;
    else if (m_st == 1 && s0 == 0 && s1 == 0 && !ovp) m_st = 2;
  endfunction

  task automatic tick(input logic [1:0] v, input logic [7:0] d0,
                      input logic [7:0] d1, input logic h,
                      input logic r);
    logic [23:0] u0, u1;
    u0 = 24'($urandom); u1 = 24'($urandom);
    in_valid = v; in_data = {u1, d1, u0, d0};
    in_halt = h; out_ready = r;
    last_hs = out_valid && r;
    if (last_hs) got.push_back({out_chan, out_char});
    @(posedge clk);
    m_step(v, d0, d1, h, r);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_halt = 0; out_ready = 0; in_data = 0;
    rst_n = 1'b0;
    #2;
    m_reset();
    got.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_halt = 0; out_ready = 0; in_data = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %0h exp 0", out_valid);
    end
    checks++;
    if (out_char !== 8'h0 || out_chan !== 1'b0) begin
      errors++;
      $display("FAIL rst_char: got %0h/%0h exp 0/0", out_char, out_chan);
    end
    checks++;
    if (overflow !== 2'b00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got %0h/%0h exp 0/0", overflow, timeout);
    end
    checks++;
    if (done !== 1'b0 || char_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_done_cnt: got %0h/%0h exp 0/0", done, char_count);
    end
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick(2'b00, 0, 0, 0, 1);
    tick(2'b00, 0, 0, 0, 1);
    tick(2'b01, 8'h48, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_nobypass: got %0h exp 0", out_valid);
    end
    tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_char !== 8'h48 || out_chan !== 1'b0) begin
      errors++;
      $display("FAIL single_out: got v%0h c%0h ch%0h exp v1 c48 ch0",
               out_valid, out_char, out_chan);
    end
    tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (char_count !== 32'd1) begin
      errors++; $display("FAIL single_count: got %0d exp 1", char_count);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp9;
    do_reset();
    for (int i = 0; i < 4; i++)
      tick(2'b11, 8'h61 + 8'(i), 8'h41 + 8'(i), 0, 1);
    for (int i = 0; i < 12; i++) tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL rr_len: got %0d exp 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      exp9 = (i % 2 == 0) ? {1'b0, 8'h61 + 8'(i / 2)}
                          : {1'b1, 8'h41 + 8'(i / 2)};
      checks++;
      if (got[i] !== exp9) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got %0h exp %0h", i, got[i], exp9);
      end
    end
    checks++;
    if (char_count !== 32'd8) begin
      errors++; $display("FAIL rr_count: got %0d exp 8", char_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(2'b01, 8'h30 + 8'(i), 0, 0, 0);
      if (i == 16) begin
        checks++;
        if (overflow !== 2'b00) begin
          errors++; $display("FAIL ovf_early: got %0h exp 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 2'b01) begin
      errors++; $display("FAIL ovf_set: got %0h exp 1", overflow);
    end
    for (int i = 0; i < 25; i++) tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (got.size() != 17) begin
      errors++; $display("FAIL ovf_len: got %0d exp 17", got.size());
    end
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== {1'b0, 8'h30 + 8'(i)}) begin
        errors++;
        $display("FAIL ovf_seq[%0d]: got %0h exp %0h", i, got[i],
                 {1'b0, 8'h30 + 8'(i)});
      end
    end
    checks++;
    if (overflow !== 2'b01) begin
      errors++; $display("FAIL ovf_sticky: got %0h exp 1", overflow);
    end
  endtask

  task automatic test_halt_drain();
    int hs_edge, done_edge;
    bit saw_q;
    do_reset();
    for (int i = 0; i < 5; i++) tick(2'b01, 8'h30 + 8'(i), 0, 0, 0);
    tick(2'b01, 8'h5A, 0, 1, 0);
    hs_edge = -1; done_edge = -1; saw_q = 0;
    for (int k = 0; k < 40; k++) begin
      tick(2'b01, 8'h51, 0, 0, (k % 2 == 0));
      if (last_hs) hs_edge = k;
      if (done === 1'b1 && done_edge < 0) done_edge = k;
    end
    checks++;
    if (got.size() != 6) begin
      errors++; $display("FAIL halt_len: got %0d exp 6", got.size());
    end
    for (int i = 0; i < got.size(); i++)
      if (got[i][7:0] == 8'h51) saw_q = 1;
    checks++;
    if (saw_q) begin
      errors++; $display("FAIL halt_noQ: got Q=1 exp Q=0");
    end
    checks++;
    if (got.size() == 0 || got[got.size()-1] !== 9'h05A) begin
      errors++;
      $display("FAIL halt_last: got %0h exp 5a",
               got.size() ? got[got.size()-1] : 9'h1FF);
    end
    checks++;
    if (done_edge < 0 || done_edge != hs_edge + 1) begin
      errors++;
      $display("FAIL halt_done_edge: got %0d exp %0d", done_edge,
               hs_edge + 1);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      tick(2'b00, 0, 0, 0, 1);
      if (i == 7) begin
        checks++;
        if (timeout !== 1'b0) begin
          errors++; $display("FAIL wd_early: got %0h exp 0", timeout);
        end
      end
    end
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL wd_fire: got %0h exp 1", timeout);
    end
    do_reset();
    for (int i = 0; i < 7; i++) tick(2'b00, 0, 0, 0, 1);
    tick(2'b01, 8'h78, 0, 0, 1);
    for (int i = 0; i < 7; i++) tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL wd_cleared: got %0h exp 0", timeout);
    end
    tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL wd_refire: got %0h exp 1", timeout);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    tick(2'b01, 8'h68, 0, 0, 0);
    tick(2'b01, 8'h69, 0, 0, 0);
    tick(2'b01, 8'h6A, 0, 0, 1);
    tick(2'b00, 0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || done !== 1'b0 || char_count !== 32'd1) begin
      errors++;
      $display("FAIL mid_pre: got v%0h d%0h n%0d exp v1 d0 n1",
               out_valid, done, char_count);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || char_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_async: got v%0h d%0h n%0d exp v0 d0 n0",
               out_valid, done, char_count);
    end
    rst_n = 1'b1;
    m_reset();
    got.delete();
    #1;
    tick(2'b10, 0, 8'h41, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_lat: got %0h exp 0", out_valid);
    end
    tick(2'b00, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_char !== 8'h41 || out_chan !== 1'b1) begin
      errors++;
      $display("FAIL mid_new: got v%0h c%0h ch%0h exp v1 c41 ch1",
               out_valid, out_char, out_chan);
    end
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic [7:0] d0, d1;
    logic r;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v  = 2'($urandom);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      r  = (n < 150) ? ($urandom_range(0, 9) < 3)
                     : ($urandom_range(0, 3) != 0);
      if (n > 40 && n < 60) v = 2'b00;
      tick(v, d0, d1, (n == 350), r);
      checks++;
      if (out_valid !== m_ov) begin
        errors++;
        $display("FAIL rnd_valid@%0d: got %0h exp %0h", n, out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if (out_char !== m_char || out_chan !== m_chan) begin
          errors++;
          $display("FAIL rnd_data@%0d: got %0h/%0h exp %0h/%0h", n,
                   out_char, out_chan, m_char, m_chan);
        end
      end
      checks++;
      if (overflow !== m_ovf || timeout !== m_to) begin
        errors++;
        $display("FAIL rnd_flags@%0d: got %0h/%0h exp %0h/%0h", n,
                 overflow, timeout, m_ovf, m_to);
      end
      checks++;
      if (done !== (m_st == 2) || char_count !== m_cnt) begin
        errors++;
        $display("FAIL rnd_done_cnt@%0d: got %0h/%0d exp %0h/%0d", n,
                 done, char_count, (m_st == 2), m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_halt_drain();
    test_watchdog();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
